bmu_issue_stage: RTL and testbench



---
 rtl/rtl_pkg.sv | 36 +++
 rtl/bmu_issue_fifo.sv | 40 ++++
 rtl/bmu_issue_stage.sv | 115 +++++++++++
 tb/tb_bmu_issue_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtl_pkg.sv
// rtl_pkg: shared ALU op packet and BMU issue-stage entry types.
package rtl_pkg;

    typedef struct packed {
        logic clz;
        logic ctz;
        logic cpop;
        logic sext_b;
        logic sext_h;
        logic min;
        logic max;
        logic pack;
        logic packu;
        logic packh;
        logic rol;
        logic ror;
        logic grev;
        logic gorc;
        logic bset;
        logic bclr;
    } rtl_alu_pkt_t;

    localparam int BMU_DEF_LAT = 1;
    localparam int BMU_TAG_W   = 5;

    // rd is stored at the package tag width; the issue stage's TAG_W should match it.
    typedef struct packed {
        rtl_alu_pkt_t         ap;
        logic                 csr_ren;
        logic [31:0]          csr_rddata;
        logic [31:0]          a;
        logic [31:0]          b;
        logic [BMU_TAG_W-1:0] rd;
    } bmu_issue_entry_t;

endpackage

// File: rtl/bmu_issue_fifo.sv
// bmu_issue_fifo: sync FIFO of BMU issue entries with push/pop/clear and fill count.
module bmu_issue_fifo
    import rtl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     clear,
    input  logic                     push,
    input  bmu_issue_entry_t         push_data,
    input  logic                     pop,
    output bmu_issue_entry_t         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    bmu_issue_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    // Power-of-two depth makes the natural pointer rollover the modulo wrap.
    always_ff @(posedge clk) begin
        if (!rst_l || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/bmu_issue_stage.sv
// bmu_issue_stage: buffers decoded bit-manip ops, issues one per cycle to the BMU,
// and tags the BMU result as a writeback after BMU_LAT cycles.
module bmu_issue_stage
    import rtl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5,
    parameter int BMU_LAT = BMU_DEF_LAT
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   scan_mode,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  rtl_alu_pkt_t           req_ap,
    input  logic                   req_csr_ren,
    input  logic [31:0]            req_csr_rddata,
    input  logic [31:0]            req_a,
    input  logic [31:0]            req_b,
    input  logic [TAG_W-1:0]       req_rd,
    input  logic                   issue_en,
    input  logic                   flush,
    output logic                   bmu_scan_mode,
    output logic                   bmu_valid_in,
    output rtl_alu_pkt_t           bmu_ap,
    output logic                   bmu_csr_ren_in,
    output logic [31:0]            bmu_csr_rddata_in,
    output logic [31:0]            bmu_a_in,
    output logic [31:0]            bmu_b_in,
    input  logic [31:0]            bmu_result_ff,
    input  logic                   bmu_error,
    output logic                   wb_valid,
    output logic [TAG_W-1:0]       wb_rd,
    output logic [31:0]            wb_data,
    output logic                   wb_error,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int CW = $clog2(DEPTH) + 1;

    bmu_issue_entry_t req_entry, head;
    logic             push, issue;
    logic [TAG_W-1:0] bmu_rd;

    assign req_ready = occupancy < CW'(DEPTH);
    assign push      = req_valid && req_ready && !flush;
    assign issue     = (occupancy != '0) && issue_en && !flush;

    assign req_entry = '{
        ap:         req_ap,
        csr_ren:    req_csr_ren,
        csr_rddata: req_csr_rddata,
        a:          req_a,
        b:          req_b,
        rd:         BMU_TAG_W'(req_rd)
    };

    bmu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_l     (rst_l),
        .clear     (flush),
        .push      (push),
        .push_data (req_entry),
        .pop       (issue),
        .head      (head),
        .count     (occupancy)
    );

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            bmu_valid_in      <= 1'b0;
            bmu_ap            <= '0;
            bmu_csr_ren_in    <= 1'b0;
            bmu_csr_rddata_in <= '0;
            bmu_a_in          <= '0;
            bmu_b_in          <= '0;
            bmu_rd            <= '0;
        end else begin
            bmu_valid_in <= issue;
            if (issue) begin
                bmu_ap            <= head.ap;
                bmu_csr_ren_in    <= head.csr_ren;
                bmu_csr_rddata_in <= head.csr_rddata;
                bmu_a_in          <= head.a;
                bmu_b_in          <= head.b;
                bmu_rd            <= TAG_W'(head.rd);
            end
        end
    end

    // The issue register is stage 0 of the tag chain; the last element is the writeback.
    logic [BMU_LAT-1:0]            tag_v;
    logic [BMU_LAT-1:0][TAG_W-1:0] tag_rd;
    logic [BMU_LAT:0]              v_chain;
    logic [BMU_LAT:0][TAG_W-1:0]   rd_chain;

    assign v_chain  = {tag_v, bmu_valid_in};
    assign rd_chain = {tag_rd, bmu_rd};

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            tag_v  <= '0;
            tag_rd <= '0;
        end else begin
            tag_v  <= flush ? '0 : v_chain[BMU_LAT-1:0];
            tag_rd <= rd_chain[BMU_LAT-1:0];
        end
    end

    assign wb_valid      = v_chain[BMU_LAT];
    assign wb_rd         = rd_chain[BMU_LAT];
    assign wb_data       = bmu_result_ff;
    assign wb_error      = wb_valid && bmu_error;
    assign bmu_scan_mode = scan_mode;

endmodule

// File: tb/tb_bmu_issue_stage.sv
// tb_bmu_issue_stage: directed checks of the BMU issue stage against a 1-cycle BMU model.
module tb_bmu_issue_stage;
    import rtl_pkg::*;

    logic               clk = 1'b0;
    logic               rst_l, scan_mode, req_valid, req_ready;
    rtl_alu_pkt_t       req_ap, bmu_ap;
    logic               req_csr_ren, bmu_csr_ren_in;
    logic [31:0]        req_csr_rddata, req_a, req_b;
    logic [4:0]         req_rd, wb_rd;
    logic               issue_en, flush, bmu_scan_mode, bmu_valid_in;
    logic [31:0]        bmu_csr_rddata_in, bmu_a_in, bmu_b_in, bmu_result_ff, wb_data;
    logic               bmu_error, wb_valid, wb_error;
    logic [2:0]         occupancy;
    int                 n_checks = 0;
    int                 n_fail = 0;

    always #5 clk = ~clk;

    bmu_issue_stage dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .scan_mode         (scan_mode),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_ap            (req_ap),
        .req_csr_ren       (req_csr_ren),
        .req_csr_rddata    (req_csr_rddata),
        .req_a             (req_a),
        .req_b             (req_b),
        .req_rd            (req_rd),
        .issue_en          (issue_en),
        .flush             (flush),
        .bmu_scan_mode     (bmu_scan_mode),
        .bmu_valid_in      (bmu_valid_in),
        .bmu_ap            (bmu_ap),
        .bmu_csr_ren_in    (bmu_csr_ren_in),
        .bmu_csr_rddata_in (bmu_csr_rddata_in),
        .bmu_a_in          (bmu_a_in),
        .bmu_b_in          (bmu_b_in),
        .bmu_result_ff     (bmu_result_ff),
        .bmu_error         (bmu_error),
        .wb_valid          (wb_valid),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .wb_error          (wb_error),
        .occupancy         (occupancy)
    );

    // BMU stand-in: result = a ^ b, error when b == 0xBAD; both hold between ops.
    always @(posedge clk) begin
        if (bmu_valid_in) begin
            bmu_result_ff <= bmu_a_in ^ bmu_b_in;
            bmu_error     <= (bmu_b_in == 32'hBAD);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
    endtask

    initial begin
        bmu_result_ff = '0;
        bmu_error = 1'b0;
        rst_l = 1'b0; scan_mode = 1'b0; issue_en = 1'b0; flush = 1'b0;
        req_ap = '0; req_csr_ren = 1'b0; req_csr_rddata = '0;
        set_req(1'b0, 0, 0, 0);
        tick; tick;
        check("rst_occ", 64'(occupancy), 0);
        check("rst_vin", 64'(bmu_valid_in), 0);
        check("rst_a", 64'(bmu_a_in), 0);
        check("rst_wbv", 64'(wb_valid), 0);
        check("rst_wbrd", 64'(wb_rd), 0);
        scan_mode = 1'b1;
        #1 check("scan", 64'(bmu_scan_mode), 1);
        scan_mode = 1'b0;
        rst_l = 1'b1;
        tick;
        check("rdy_after_rst", 64'(req_ready), 1);

        // single op
        issue_en = 1'b1;
        req_ap = rtl_alu_pkt_t'(16'h0011);
        req_csr_ren = 1'b1;
        req_csr_rddata = 32'hCAFE;
        set_req(1'b1, 32'hF0, 32'h4, 5'd7);
        tick;
        req_valid = 1'b0;
        check("s_occ1", 64'(occupancy), 1);
        check("s_vin0", 64'(bmu_valid_in), 0);
        tick;
        check("s_vin1", 64'(bmu_valid_in), 1);
        check("s_a", 64'(bmu_a_in), 64'hF0);
        check("s_b", 64'(bmu_b_in), 64'h4);
        check("s_ap", {48'b0, bmu_ap}, 64'h0011);
        check("s_csr", {31'b0, bmu_csr_ren_in, bmu_csr_rddata_in}, 64'h1_0000_CAFE);
        check("s_wbv0", 64'(wb_valid), 0);
        tick;
        check("s_vin_off", 64'(bmu_valid_in), 0);
        check("s_wbv", 64'(wb_valid), 1);
        check("s_wbrd", 64'(wb_rd), 7);
        check("s_wbdata", 64'(wb_data), 64'hF4);
        check("s_wberr", 64'(wb_error), 0);
        tick;
        check("s_wbv_off", 64'(wb_valid), 0);

        // fill, back-pressure, push+pop at occupancy 3, pointer wrap
        issue_en = 1'b0;
        req_ap = '0; req_csr_ren = 1'b0; req_csr_rddata = '0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 32'h100 + 32'(i), 32'(i), 5'(i + 1));
            tick;
        end
        check("f_occ4", 64'(occupancy), 4);
        check("f_rdy0", 64'(req_ready), 0);
        set_req(1'b1, 32'h200, 32'h20, 5'd9);
        tick;
        check("f_held", 64'(occupancy), 4);
        issue_en = 1'b1;
        tick;
        check("f_vin", 64'(bmu_valid_in), 1);
        check("f_a0", 64'(bmu_a_in), 64'h100);
        check("f_occ3", 64'(occupancy), 3);
        check("f_rdy1", 64'(req_ready), 1);
        tick;
        check("f_a1", 64'(bmu_a_in), 64'h101);
        check("f_pushpop_occ", 64'(occupancy), 3);
        check("f_wbv0", 64'(wb_valid), 1);
        check("f_wbrd0", 64'(wb_rd), 1);
        check("f_wbd0", 64'(wb_data), 64'h100);
        req_valid = 1'b0;
        tick;
        check("f_a2", 64'(bmu_a_in), 64'h102);
        check("f_occ2", 64'(occupancy), 2);
        check("f_wbrd1", 64'(wb_rd), 2);
        tick;
        check("f_a3", 64'(bmu_a_in), 64'h103);
        tick;
        check("f_wrap_a", 64'(bmu_a_in), 64'h200);
        check("f_wrap_b", 64'(bmu_b_in), 64'h20);
        check("f_occ0", 64'(occupancy), 0);
        check("f_wbrd3", 64'(wb_rd), 4);
        tick;
        check("f_vin_off", 64'(bmu_valid_in), 0);
        check("f_wbrd_wrap", 64'(wb_rd), 9);
        check("f_wbd_wrap", 64'(wb_data), 64'h220);
        tick;
        check("f_wbv_off", 64'(wb_valid), 0);

        // error forwarding on the second of two ops
        set_req(1'b1, 32'h1, 32'h2, 5'd3);
        tick;
        set_req(1'b1, 32'h5, 32'hBAD, 5'd4);
        tick;
        req_valid = 1'b0;
        tick;
        check("e_wbv1", 64'(wb_valid), 1);
        check("e_rd1", 64'(wb_rd), 3);
        check("e_err1", 64'(wb_error), 0);
        check("e_d1", 64'(wb_data), 64'h3);
        tick;
        check("e_rd2", 64'(wb_rd), 4);
        check("e_err2", 64'(wb_error), 1);
        check("e_d2", 64'(wb_data), 64'hBA8);
        tick;
        check("e_idle_v", 64'(wb_valid), 0);
        check("e_idle_err", 64'(wb_error), 0);

        // flush with three buffered and one in flight
        issue_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 32'h300 + 32'(i), 32'h0, 5'(10 + i));
            tick;
        end
        req_valid = 1'b0;
        issue_en = 1'b1;
        tick;
        check("x_inflight", 64'(bmu_valid_in), 1);
        check("x_occ3", 64'(occupancy), 3);
        flush = 1'b1;
        set_req(1'b1, 32'h3FF, 32'h0, 5'd15);
        #1 check("x_rdy", 64'(req_ready), 1);
        tick;
        check("x_occ0", 64'(occupancy), 0);
        check("x_vin0", 64'(bmu_valid_in), 0);
        check("x_wbv0", 64'(wb_valid), 0);
        flush = 1'b0;
        req_valid = 1'b0;
        tick;
        check("x_drop", 64'(occupancy), 0);
        check("x_vin", 64'(bmu_valid_in), 0);
        check("x_wbv1", 64'(wb_valid), 0);

        // reset mid-operation with two ops buffered
        issue_en = 1'b0;
        set_req(1'b1, 32'h400, 32'h1, 5'd20);
        tick;
        set_req(1'b1, 32'h401, 32'h1, 5'd21);
        tick;
        req_valid = 1'b0;
        check("r_occ2", 64'(occupancy), 2);
        rst_l = 1'b0;
        tick;
        check("r_occ", 64'(occupancy), 0);
        check("r_vin", 64'(bmu_valid_in), 0);
        check("r_a", 64'(bmu_a_in), 0);
        check("r_ap", {48'b0, bmu_ap}, 0);
        check("r_wbv", 64'(wb_valid), 0);
        check("r_wbrd", 64'(wb_rd), 0);
        check("r_wberr", 64'(wb_error), 0);
        rst_l = 1'b1;
        issue_en = 1'b1;
        tick;
        check("r_rdy", 64'(req_ready), 1);
        check("r_no_issue", 64'(bmu_valid_in), 0);
        tick;
        check("r_no_wb", 64'(wb_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
